// File: rtl/ram32x4_fifo_ctrl_if.sv
// Ready/valid handshake bundle for the 32x4 FIFO controller.
// The slave modport is the FIFO side; the master modport is the producer/consumer side.
interface ram32x4_fifo_ctrl_if #(
  parameter int DATA_W = 4
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/ram32x4_fifo_ctrl.sv
// First-word-fall-through FIFO controller wrapped around an external 32x4
// single-port RAM (synchronous write, asynchronous read). Writes own the RAM
// port whenever they occur; reads move the head entry into a registered
// output stage during cycles without a write.
module ram32x4_fifo_ctrl #(
  parameter int DATA_W       = 4,
  parameter int ADDR_W       = 5,
  parameter int AFULL_THRESH = 28
) (
  input  logic              clk,
  input  logic              rst,
  ram32x4_fifo_ctrl_if.slave bus,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_d,
  input  logic [DATA_W-1:0] ram_o,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              almost_full,
  output logic              empty
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   CNT_ZERO  = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_FULL  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_AFULL = (ADDR_W+1)'(AFULL_THRESH);
  localparam logic [ADDR_W-1:0] PTR_ZERO  = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W:0]   count_next;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              in_ready;
  logic              wr;
  logic              rd;

  // Status flags decoded from the RAM occupancy and the output register.
  always_comb begin
    full        = (count == CNT_FULL);
    almost_full = (count >= CNT_AFULL);
    empty       = (count == CNT_ZERO) && !out_valid;
  end

  // Port arbitration: a write takes the RAM port, otherwise the head is read
  // whenever the output register is free or being consumed this cycle.
  always_comb begin
    in_ready   = 1'b0;
    wr         = 1'b0;
    rd         = 1'b0;
    ram_addr   = rptr;
    count_next = count;
    if (rst) begin
      in_ready = 1'b0;
    end else begin
      in_ready = !full;
    end
    wr = bus.in_valid && in_ready;
    rd = !wr && (count != CNT_ZERO) && (!out_valid || bus.out_ready);
    if (wr) begin
      ram_addr = wptr;
    end else begin
      ram_addr = rptr;
    end
    case ({wr, rd})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  assign ram_we        = wr;
  assign ram_d         = bus.in_data;
  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data;
  assign bus.out_valid = out_valid;

  // Pointer, occupancy and output-stage state; reset discards in-flight data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= PTR_ZERO;
      rptr      <= PTR_ZERO;
      count     <= CNT_ZERO;
      out_data  <= DATA_ZERO;
      out_valid <= 1'b0;
    end else begin
      if (wr) begin
        wptr <= wptr + PTR_ONE;
      end
      if (rd) begin
        out_data  <= ram_o;
        out_valid <= 1'b1;
        rptr      <= rptr + PTR_ONE;
      end else if (out_valid && bus.out_ready) begin
        out_valid <= 1'b0;
      end
      count <= count_next;
    end
  end

endmodule

// File: tb/tb_ram32x4_fifo_ctrl.sv
// Self-checking bench for ram32x4_fifo_ctrl: a behavioural 32x4 RAM, a
// data-ordering scoreboard, a per-cycle vector table and corner sequences.
module tb_ram32x4_fifo_ctrl;
  localparam int DW = 4;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_d;
  logic [DW-1:0] ram_o;
  logic [AW:0]   count;
  logic          full;
  logic          almost_full;
  logic          empty;
  logic [DW-1:0] mem [32];

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] sb [$];

  ram32x4_fifo_ctrl_if #(.DATA_W(DW)) bus ();

  ram32x4_fifo_ctrl #(.DATA_W(DW), .ADDR_W(AW), .AFULL_THRESH(28)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_d(ram_d), .ram_o(ram_o),
    .count(count), .full(full), .almost_full(almost_full), .empty(empty)
  );

  always #5 clk = ~clk;

  // External RAM: synchronous write, asynchronous read
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_d;
  assign ram_o = mem[ram_addr];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: push accepted writes, compare consumed output in order
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow actual=%0h expected=none", bus.out_data);
        end else begin
          check("out_data_order", int'(bus.out_data), int'(sb.pop_front()));
        end
      end
      if (bus.in_valid && bus.in_ready) sb.push_back(bus.in_data);
    end
  end

  typedef struct {
    logic          iv;
    logic [DW-1:0] id;
    logic          ordy;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic          e_rdy;
    logic [AW:0]   e_cnt;
    logic          e_ov;
    logic          e_empty;
  } vec_t;

  vec_t tbl [15];

  task automatic drive(input logic iv, input logic [DW-1:0] d, input logic ordy);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    drive(1'b0, 4'h0, 1'b1);
    for (int k = 0; k < 80 && (bus.out_valid || count != 0); k++) tick();
    check("drain_empty", int'(empty), 1);
  endtask

  initial begin
    int exp_cnt;
    //             iv    id     ordy  we    addr   rdy   cnt   ov    empty
    tbl[0]  = '{1'b0, 4'h0, 1'b1, 1'b0, 5'd0, 1'b1, 6'd0, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 4'hA, 1'b1, 1'b1, 5'd0, 1'b1, 6'd1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 4'h0, 1'b1, 1'b0, 5'd0, 1'b1, 6'd0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 4'h0, 1'b1, 1'b0, 5'd1, 1'b1, 6'd0, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 4'h1, 1'b0, 1'b1, 5'd1, 1'b1, 6'd1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 4'h2, 1'b0, 1'b1, 5'd2, 1'b1, 6'd2, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 4'h3, 1'b0, 1'b1, 5'd3, 1'b1, 6'd3, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 4'h4, 1'b0, 1'b1, 5'd4, 1'b1, 6'd4, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 4'h0, 1'b0, 1'b0, 5'd1, 1'b1, 6'd3, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 4'h5, 1'b1, 1'b1, 5'd5, 1'b1, 6'd4, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 4'h0, 1'b1, 1'b0, 5'd2, 1'b1, 6'd3, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 4'h0, 1'b1, 1'b0, 5'd3, 1'b1, 6'd2, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 4'h0, 1'b1, 1'b0, 5'd4, 1'b1, 6'd1, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 4'h0, 1'b1, 1'b0, 5'd5, 1'b1, 6'd0, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 4'h0, 1'b1, 1'b0, 5'd6, 1'b1, 6'd0, 1'b0, 1'b1};

    for (int i = 0; i < 32; i++) mem[i] = 4'h0;
    drive(1'b0, 4'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready_held", int'(bus.in_ready), 0);
    rst = 1'b0;
    #1;
    check("rst_empty", int'(empty), 1);
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_data", int'(bus.out_data), 0);
    check("rst_count", int'(count), 0);
    check("rst_full", int'(full), 0);
    check("rst_afull", int'(almost_full), 0);
    check("rst_ram_addr", int'(ram_addr), 0);

    // Per-cycle vectors: single item latency and write-vs-consume collision
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].iv, tbl[i].id, tbl[i].ordy);
      #1;
      check($sformatf("v%0d_ram_we", i), int'(ram_we), int'(tbl[i].e_we));
      check($sformatf("v%0d_ram_addr", i), int'(ram_addr), int'(tbl[i].e_addr));
      check($sformatf("v%0d_in_ready", i), int'(bus.in_ready), int'(tbl[i].e_rdy));
      tick();
      check($sformatf("v%0d_count", i), int'(count), int'(tbl[i].e_cnt));
      check($sformatf("v%0d_out_valid", i), int'(bus.out_valid), int'(tbl[i].e_ov));
      check($sformatf("v%0d_empty", i), int'(empty), int'(tbl[i].e_empty));
    end

    // Fill to full: one write, one idle (moves head out), then 31 writes -> 31, then one more
    exp_cnt = 0;
    for (int i = 0; i < 33; i++) begin
      drive(1'b1, 4'(i), 1'b0);
      tick();
      exp_cnt++;
      if (i == 0) begin
        drive(1'b0, 4'h0, 1'b0);
        tick();
        exp_cnt--;
        check("fill_head_valid", int'(bus.out_valid), 1);
      end
      check("fill_count", int'(count), exp_cnt);
      check("fill_afull", int'(almost_full), int'(exp_cnt >= 28));
      check("fill_full", int'(full), int'(exp_cnt == 32));
    end
    check("full_in_ready", int'(bus.in_ready), 0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'hF, 1'b0);
      #1;
      check("full_ignored_we", int'(ram_we), 0);
      tick();
      check("full_count_held", int'(count), 32);
    end
    drain();
    check("fill_sb_empty", sb.size(), 0);

    // Pointer wrap: 40 items in bursts of 5 writes then 4 consume-only cycles
    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k < 5; k++) begin
        drive(1'b1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        tick();
      end
      for (int k = 0; k < 4; k++) begin
        drive(1'b0, 4'h0, 1'b1);
        tick();
      end
    end
    drain();
    check("wrap_sb_empty", sb.size(), 0);

    // Reset mid-burst with 10 entries held in RAM
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 4'(i + 3), 1'b0);
      tick();
    end
    check("pre_rst_count", int'(count), 10);
    rst = 1'b1;
    sb.delete();
    #1;
    check("mid_rst_out_valid", int'(bus.out_valid), 0);
    check("mid_rst_count", int'(count), 0);
    check("mid_rst_ram_we", int'(ram_we), 0);
    check("mid_rst_in_ready", int'(bus.in_ready), 0);
    tick();
    drive(1'b1, 4'h7, 1'b0);
    rst = 1'b0;
    #1;
    check("post_rst_we", int'(ram_we), 1);
    check("post_rst_addr", int'(ram_addr), 0);
    tick();
    drive(1'b0, 4'h0, 1'b0);
    tick();
    check("post_rst_out_valid", int'(bus.out_valid), 1);
    check("post_rst_out_data", int'(bus.out_data), 7);
    drain();
    check("rst_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram32x4_fifo_ctrl.md
Name: ram32x4_fifo_ctrl

Overview:
- Control stage that sits directly upstream of a 32x4 single-port distributed RAM with synchronous write and asynchronous read.
- Turns that RAM into a 32-entry, 4-bit-wide first-word-fall-through FIFO.
- Drives the RAM address, write-enable and data pins, and captures the asynchronous RAM output into a registered output stage.
- Ready/valid handshake on both the input and output sides.

Parameters:
- DATA_W, 4, data width; must match the RAM width.
- ADDR_W, 5, RAM address width; DEPTH = 2**ADDR_W = 32.
- AFULL_THRESH, 28, ALMOST_FULL asserts when COUNT >= this value.

Ports:
- CLK  in  1  single clock; also drives the RAM WCLK.
- RST  in  1  asynchronous, active-high reset.
- IN_DATA  in  DATA_W  write data.
- IN_VALID  in  1  write request.
- IN_READY  out  1  controller can accept a write (comb).
- OUT_DATA  out  DATA_W  registered head-of-FIFO data.
- OUT_VALID  out  1  OUT_DATA holds a valid entry.
- OUT_READY  in  1  consumer takes OUT_DATA.
- RAM_ADDR  out  ADDR_W  RAM address (comb).
- RAM_WE  out  1  RAM write enable (comb).
- RAM_D  out  DATA_W  RAM write data (comb, = IN_DATA).
- RAM_O  in  DATA_W  RAM asynchronous read data.
- COUNT  out  ADDR_W+1  entries held in RAM, 0..32; excludes the output register.
- FULL  out  1  COUNT == 32.
- ALMOST_FULL  out  1  COUNT >= AFULL_THRESH.
- EMPTY  out  1  COUNT == 0 and OUT_VALID == 0.

Behaviour:
- Clock and reset: one clock (CLK); reset RST is asynchronous and active-high.
- Reset state:
  - wptr = 0, rptr = 0, COUNT = 0.
  - OUT_VALID = 0, OUT_DATA = 0.
  - FULL = 0, ALMOST_FULL = 0, EMPTY = 1.
  - IN_READY forced to 0 while RST is high, so RAM_WE = 0 immediately.
  - RAM contents are not cleared.
- Internal state: wptr and rptr are ADDR_W bits and wrap naturally 31 -> 0.
- Write condition: wr = IN_VALID & IN_READY, where IN_READY = !FULL & !RST.
- Read condition: rd = !wr & (COUNT != 0) & (!OUT_VALID | OUT_READY).
- Port arbitration: the RAM is single-port and writes have priority.
  - RAM_ADDR = wr ? wptr : rptr.
  - RAM_WE = wr.
  - RAM_D = IN_DATA.
- Rising edge with wr: the RAM captures IN_DATA at wptr, then wptr += 1.
- Rising edge with rd: OUT_DATA <= RAM_O (value at rptr), OUT_VALID <= 1, rptr += 1.
- Rising edge with !rd and OUT_VALID & OUT_READY: OUT_VALID <= 0; OUT_DATA holds its last value.
- COUNT next = COUNT + wr - rd. wr and rd are mutually exclusive, so COUNT never changes by more than 1 per cycle.
- Latency:
  - An item accepted at edge N into an empty FIFO appears with OUT_VALID = 1 after edge N+1, provided no write occurs in cycle N+1.
  - Sustained back-to-back reads give one item per cycle.
- Starvation: continuous writes block reads. This is intended. Upstream must throttle; ALMOST_FULL is provided for that.
- FULL: IN_READY = 0, and IN_VALID is ignored (no RAM write, no pointer change).
- Simultaneous IN_VALID and output consume while OUT_VALID = 1 and COUNT > 0:
  - The write wins.
  - OUT_VALID drops for one cycle.
  - The next cycle refills the output register.
- Empty RAM with OUT_VALID = 1 and OUT_READY = 1: OUT_VALID -> 0 and EMPTY -> 1 on that edge.
- Reset mid-operation: all state clears asynchronously and in-flight data is lost. The first write after RST deasserts goes to address 0.
- Ordering: strict FIFO order, including across pointer wrap.

Test Plan:
- RST high, then low, with no traffic -> EMPTY = 1, IN_READY = 1, OUT_VALID = 0, OUT_DATA = 4'h0, COUNT = 0; RAM_ADDR = 0 while idle.
- Write 4'hA once, OUT_READY = 1 -> RAM_WE = 1 with RAM_ADDR = 0 in the write cycle; OUT_VALID = 1 with OUT_DATA = 4'hA one edge later; EMPTY = 1 after the consume edge.
- Write 32 items 0..F,0..F with OUT_READY = 0 -> COUNT steps to 31 (one item moves to the output register when writes pause); ALMOST_FULL set at COUNT = 28.
  - Write one more -> FULL = 1, IN_READY = 0.
  - Extra IN_VALID cycles are ignored.
  - Drain sequence matches the input exactly.
- Pointer wrap: push/pop 40 items in interleaved bursts -> wptr and rptr cross 31 -> 0 and output order is preserved.
- Simultaneous IN_VALID and OUT_READY with COUNT = 3 and OUT_VALID = 1 -> that edge writes and sets OUT_VALID = 0; the next idle edge sets OUT_VALID = 1 with the correct next item; COUNT goes 3 -> 4 -> 3.
- Assert RST mid-burst with COUNT = 10 -> asynchronously OUT_VALID = 0, COUNT = 0, RAM_WE = 0 and IN_READY = 0 during reset; the next write after release targets address 0.
